aes_128_inv_control: RTL

Sequencing controller for the AES-128 inverse cipher (decrypt) datapath. It mirrors the encrypt-side control: 10 rounds, 3 cycles per round, 4-BRAM inverse S-box datapath. Decryption consumes round keys in reverse order, so the block also runs a key-precompute phase. That phase writes all 11 round keys into a key RAM; decrypt rounds then read them back from address 10 down to 0.

---
 rtl/aes_128_inv_control.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/aes_128_inv_control.sv
// Sequencing controller for the AES-128 inverse cipher datapath.
// A key-precompute phase writes all round keys into a key RAM. Decryption
// then fetches them in reverse order, one per round, with a fixed
// ROUND_CYCLES cadence, and flags the final round and the plaintext strobe.
module aes_128_inv_control #(
  parameter int ROUNDS       = 10,
  parameter int ROUND_CYCLES = 3
) (
  input  logic       clk,
  input  logic       kill_n,
  input  logic       key_load,
  input  logic       in_en,
  output logic       key_exp_step,
  output logic       key_wr,
  output logic [3:0] key_waddr,
  output logic       key_valid,
  output logic       key_rd,
  output logic [3:0] key_raddr,
  output logic       last_round,
  output logic       out_en,
  output logic       busy,
  output logic       collision_irq_pulse
);

  // Last value of the decrypt cycle counter; out_en is registered on it.
  localparam int LAST = ROUNDS * ROUND_CYCLES - 1;
  localparam int CW   = $clog2(LAST + 1);
  localparam int PW   = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

  localparam logic [CW-1:0] RC_LAST     = CW'(LAST);
  // Registered one cycle early so last_round lines up with the first
  // cycle of the final round.
  localparam logic [CW-1:0] RC_LAST_RND = CW'(LAST - ROUND_CYCLES);
  localparam logic [PW-1:0] PH_LAST     = PW'(ROUND_CYCLES - 1);
  localparam logic [PW-1:0] PH_FETCH    = PW'(1);
  localparam logic [3:0]    ADDR_TOP    = 4'(ROUNDS);
  localparam logic [3:0]    ADDR_FIRST  = 4'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_start;
  logic            w_kexp_start;
  logic            w_collision;

  logic [3:0]      r_waddr;
  logic            r_key_valid;
  logic [3:0]      r_raddr;
  logic [CW-1:0]   r_round_count;
  logic [PW-1:0]   r_phase;
  logic            r_key_rd;
  logic            r_last_round;
  logic            r_out_en;
  logic            r_collision;

  // State register.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, request arbitration and collision detection.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_kexp_start = 1'b0;
    w_collision  = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_load) begin
          // key_load has priority; a simultaneous in_en is rejected.
          w_kexp_start = 1'b1;
          w_state_next = KEXP;
          if (in_en) w_collision = 1'b1;
        end else if (in_en) begin
          if (r_key_valid) begin
            w_start      = 1'b1;
            w_state_next = DEC;
          end else begin
            w_collision = 1'b1;
          end
        end
      end
      KEXP: begin
        if (key_load) begin
          w_kexp_start = 1'b1;
          w_collision  = 1'b1;
        end else if (r_waddr == ADDR_TOP) begin
          w_state_next = IDLE;
        end
        if (in_en) w_collision = 1'b1;
      end
      DEC: begin
        if (in_en) begin
          // Restart; back-to-back on the out_en cycle is a legal handoff.
          w_start = 1'b1;
          if (!r_out_en) w_collision = 1'b1;
        end else if (r_out_en) begin
          w_state_next = IDLE;
        end
        if (key_load) w_collision = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Key precompute: write address walk and key_valid tracking.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_waddr     <= 4'd0;
      r_key_valid <= 1'b0;
    end else if (w_kexp_start) begin
      r_waddr     <= 4'd0;
      r_key_valid <= 1'b0;
    end else if (r_state == KEXP) begin
      if (r_waddr == ADDR_TOP) begin
        r_key_valid <= 1'b1;
      end else begin
        r_waddr <= r_waddr + 4'd1;
      end
    end
  end

  // Decrypt sequencing: cycle counter, round phase and registered strobes.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_round_count <= '0;
      r_phase       <= '0;
      r_raddr       <= ADDR_FIRST;
      r_key_rd      <= 1'b0;
      r_last_round  <= 1'b0;
      r_out_en      <= 1'b0;
    end else if (w_start) begin
      r_round_count <= '0;
      r_phase       <= '0;
      r_raddr       <= ADDR_FIRST;
      r_key_rd      <= 1'b0;
      r_last_round  <= 1'b0;
      r_out_en      <= 1'b0;
    end else if (r_state == DEC) begin
      r_round_count <= (r_round_count == RC_LAST) ? r_round_count : r_round_count + 1'b1;
      r_phase       <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      r_key_rd      <= (r_phase == PH_FETCH) && (r_round_count != RC_LAST);
      r_last_round  <= (r_round_count == RC_LAST_RND);
      r_out_en      <= (r_round_count == RC_LAST) && !r_out_en;
      if (r_key_rd && (r_raddr != 4'd0)) begin
        r_raddr <= r_raddr - 4'd1;
      end
    end else begin
      r_key_rd     <= 1'b0;
      r_last_round <= 1'b0;
      r_out_en     <= 1'b0;
    end
  end

  // Collision interrupt is reported the cycle after the offending request.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_collision;
    end
  end

  assign key_wr              = (r_state == KEXP);
  assign key_waddr           = (r_state == KEXP) ? r_waddr : 4'd0;
  assign key_exp_step        = (r_state == KEXP) && (r_waddr != ADDR_TOP);
  assign key_valid           = r_key_valid;
  // Initial AddRoundKey fetch is combinational from the accepted in_en.
  assign key_rd              = w_start | r_key_rd;
  assign key_raddr           = w_start ? ADDR_TOP : (r_key_rd ? r_raddr : 4'd0);
  assign last_round          = r_last_round;
  assign out_en              = r_out_en;
  assign busy                = (r_state != IDLE);
  assign collision_irq_pulse = r_collision;

endmodule
